// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer.
// Define IMM_EXTEND_CNT_EN to add the 16-bit transfer counter output.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o
`ifdef IMM_EXTEND_CNT_EN
  ,
  output logic [15:0]      xfer_cnt_o
`endif
);

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must be >= 2");
  end

  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be >= IN_W + 2");
  end

  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] uext;
  logic [OUT_W-1:0] bext;
  logic [OUT_W-1:0] ext;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [OUT_W-1:0] main_q;
  logic [OUT_W-1:0] main_d;
  logic [OUT_W-1:0] skid_q;
  logic [OUT_W-1:0] skid_d;
  logic             valid_q;
  logic             valid_d;
  logic             ready_q;
  logic             ready_d;

  logic             accept;
  logic             xfer;

  // Build every extension form, then pick one by mode
  always_comb begin
    sext = {{PAD_W{data_i[IN_W-1]}}, data_i};
    zext = {{PAD_W{1'b0}}, data_i};
    uext = {data_i, {PAD_W{1'b0}}};
    bext = {sext[OUT_W-3:0], 2'b00};
    ext  = sext;
    unique case (mode_i)
      MODE_SIGN:   ext = sext;
      MODE_ZERO:   ext = zext;
      MODE_UPPER:  ext = uext;
      MODE_BRANCH: ext = bext;
      default:     ext = sext;
    endcase
  end

  assign accept = valid_i & ready_q;
  assign xfer   = valid_q & ready_i;

  // Skid-buffer occupancy and data movement
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = ext;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !xfer) begin
          skid_d  = ext;
          state_d = ST_FULL;
        end else if (accept && xfer) begin
          main_d  = ext;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  // State and handshake registers; reset drops buffered items
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign data_o  = main_q;

`ifdef IMM_EXTEND_CNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Transfer count, wrapping naturally at 16 bits
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe.
// Counter tests run when IMM_EXTEND_CNT_EN is defined.
module tb_imm_extend_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] data_i = '0;
  logic [1:0]  mode_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
`ifdef IMM_EXTEND_CNT_EN
  logic [15:0] xfer_cnt_o;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0] sbq[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  int unsigned model_cnt = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .mode_i  (mode_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
`ifdef IMM_EXTEND_CNT_EN
    ,
    .xfer_cnt_o (xfer_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ext_model(
    input logic [15:0] d,
    input logic [1:0]  m
  );
    logic signed [31:0] s;
    s = {{16{d[15]}}, d};
    case (m)
      2'b00:   return s;
      2'b01:   return {16'h0000, d};
      2'b10:   return {d, 16'h0000};
      default: return s <<< 2;
    endcase
  endfunction

  // Scoreboard and output-stability monitor, sampled mid-cycle
  always @(negedge clk_i) begin
    logic [31:0] exp;
    if (hold_v) begin
      chk_cnt++;
      if (valid_o !== 1'b1 || data_o !== hold_d)
        $display("FAIL stable: valid_o=%b data_o=%h want 1 %h",
                 valid_o, data_o, hold_d);
      else
        pass_cnt++;
    end
    if (rst_i) begin
      sbq.delete();
      hold_v = 1'b0;
      model_cnt = 0;
    end else begin
      if (valid_o === 1'b1 && ready_i) begin
        chk_cnt++;
        if (sbq.size() == 0) begin
          $display("FAIL sb_extra: data_o=%h with no item expected",
                   data_o);
        end else begin
          exp = sbq.pop_front();
          if (data_o !== exp)
            $display("FAIL sb_data: data_o=%h want %h", data_o, exp);
          else
            pass_cnt++;
        end
        model_cnt++;
      end
      if (valid_i && ready_o === 1'b1)
        sbq.push_back(ext_model(data_i, mode_i));
      hold_v = (valid_o === 1'b1) && !ready_i;
      hold_d = data_o;
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] m);
    valid_i = 1'b1;
    data_i  = d;
    mode_i  = m;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    cyc();
    cyc();
    @(negedge clk_i);
    chk_cnt++;
    if (valid_o !== 1'b0 || data_o !== 32'h0 || ready_o !== 1'b1)
      $display("FAIL reset: v=%b d=%h r=%b want 0 00000000 1",
               valid_o, data_o, ready_o);
    else
      pass_cnt++;
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_sign();
    ready_i = 1'b1;
    cyc();
    drive(16'h8001, 2'b00);
    cyc();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++;
    if (valid_o !== 1'b1 || data_o !== 32'hFFFF8001)
      $display("FAIL sign: v=%b d=%h want 1 FFFF8001",
               valid_o, data_o);
    else
      pass_cnt++;
    cyc();
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    cyc();
    drive(16'h8001, 2'b01);
    cyc();
    drive(16'h1234, 2'b10);
    @(negedge clk_i);
    chk_cnt++;
    if (data_o !== 32'h00008001 || ready_o !== 1'b1)
      $display("FAIL b2b_zero: d=%h r=%b want 00008001 1",
               data_o, ready_o);
    else
      pass_cnt++;
    cyc();
    drive(16'hFFFF, 2'b11);
    @(negedge clk_i);
    chk_cnt++;
    if (data_o !== 32'h12340000 || ready_o !== 1'b1)
      $display("FAIL b2b_upper: d=%h r=%b want 12340000 1",
               data_o, ready_o);
    else
      pass_cnt++;
    cyc();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++;
    if (valid_o !== 1'b1 || data_o !== 32'hFFFFFFFC || ready_o !== 1'b1)
      $display("FAIL b2b_branch: v=%b d=%h r=%b want 1 FFFFFFFC 1",
               valid_o, data_o, ready_o);
    else
      pass_cnt++;
    cyc();
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    cyc();
    drive(16'h0001, 2'b00);
    cyc();
    drive(16'h0002, 2'b00);
    cyc();
    valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk_cnt++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 32'h1)
        $display("FAIL bp_full%0d: r=%b v=%b d=%h want 0 1 00000001",
                 i, ready_o, valid_o, data_o);
      else
        pass_cnt++;
      cyc();
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    chk_cnt++;
    if (data_o !== 32'h1)
      $display("FAIL bp_first: d=%h want 00000001", data_o);
    else
      pass_cnt++;
    cyc();
    @(negedge clk_i);
    chk_cnt++;
    if (data_o !== 32'h2 || ready_o !== 1'b1 || valid_o !== 1'b1)
      $display("FAIL bp_second: d=%h r=%b v=%b want 00000002 1 1",
               data_o, ready_o, valid_o);
    else
      pass_cnt++;
    cyc();
    @(negedge clk_i);
    chk_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL bp_drain: v=%b want 0", valid_o);
    else
      pass_cnt++;
  endtask

  task automatic test_branch();
    ready_i = 1'b1;
    cyc();
    drive(16'h7FFF, 2'b11);
    cyc();
    drive(16'h8000, 2'b11);
    @(negedge clk_i);
    chk_cnt++;
    if (data_o !== 32'h0001FFFC)
      $display("FAIL br_pos: d=%h want 0001FFFC", data_o);
    else
      pass_cnt++;
    cyc();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++;
    if (data_o !== 32'hFFFE0000)
      $display("FAIL br_neg: d=%h want FFFE0000", data_o);
    else
      pass_cnt++;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc();
      valid_i = 1'($urandom_range(0, 1));
      ready_i = ($urandom_range(0, 3) != 0);
      data_i  = 16'($urandom);
      mode_i  = 2'($urandom);
    end
    cyc();
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) cyc();
    @(negedge clk_i);
    chk_cnt++;
    if (sbq.size() != 0 || valid_o !== 1'b0)
      $display("FAIL rand_drain: left=%0d v=%b want 0 0",
               sbq.size(), valid_o);
    else
      pass_cnt++;
  endtask

  task automatic test_reset_full();
    ready_i = 1'b0;
    cyc();
    drive(16'hAAAA, 2'b01);
    cyc();
    drive(16'h5555, 2'b01);
    cyc();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++;
    if (ready_o !== 1'b0)
      $display("FAIL rf_full: r=%b want 0", ready_o);
    else
      pass_cnt++;
    cyc();
    rst_i = 1'b1;
    drive(16'h1111, 2'b00);
    cyc();
    rst_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    chk_cnt++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL rf_reset: v=%b r=%b want 0 1", valid_o, ready_o);
    else
      pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk_i);
      chk_cnt++;
      if (valid_o !== 1'b0)
        $display("FAIL rf_quiet%0d: v=%b want 0", i, valid_o);
      else
        pass_cnt++;
    end
  endtask

`ifdef IMM_EXTEND_CNT_EN
  task automatic stream(input int n);
    ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      drive(16'($urandom), 2'($urandom));
    end
    cyc();
    valid_i = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_counter();
    stream(5);
    @(negedge clk_i);
    chk_cnt++;
    if (xfer_cnt_o !== 16'd5)
      $display("FAIL cnt_5: cnt=%h want 0005", xfer_cnt_o);
    else
      pass_cnt++;
    stream(65530);
    @(negedge clk_i);
    chk_cnt++;
    if (xfer_cnt_o !== 16'hFFFF || model_cnt != 65535)
      $display("FAIL cnt_max: cnt=%h seen=%0d want FFFF 65535",
               xfer_cnt_o, model_cnt);
    else
      pass_cnt++;
    stream(1);
    @(negedge clk_i);
    chk_cnt++;
    if (xfer_cnt_o !== 16'h0000)
      $display("FAIL cnt_wrap: cnt=%h want 0000", xfer_cnt_o);
    else
      pass_cnt++;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sign();
    test_back_to_back();
    test_backpressure();
    test_branch();
    test_random();
    test_reset_full();
`ifdef IMM_EXTEND_CNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
